pc_fetch_unit: RTL

//  Program counter and instruction-fetch stage, directly upstream of decode/branch evaluation.

---
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: sequences PC, handshakes with imem, feeds IF/ID.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VEC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush,
    output logic        misalign_trap
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [2:0]  FLUSH_INIT = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        flush_q, flush_d;
    logic        trap_q, trap_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;

    logic        redirect;
    logic [31:0] raw_target;
    logic        misaligned;
    logic [31:0] redirect_pc;

    assign redirect   = take_branch | jump;
    assign raw_target = jump ? jump_target : branch_target;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (raw_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Without the trap feature the low target bits are simply dropped.
    assign redirect_pc = misaligned ? TRAP_VEC : (raw_target & ~32'h3);

    always_comb begin
        // NOTE: every *_d defaults to its *_q (or pulse-clear) first so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        flush_cnt_d = flush_cnt_q;
        flush_d     = 1'b0;
        trap_d      = 1'b0;

        if (redirect) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            flush_d    = 1'b1;
            trap_d     = misaligned;
            if (FLUSH_CYCLES != 0) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_INIT;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            unique case (state_q)
                ST_BOOT: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            if_instr_d = imem_rdata;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            if_valid_d = 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if_valid_d = 1'b0;
                    if (flush_cnt_q == 3'd0) begin
                        state_d = ST_FETCH;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_instr_q  <= NOP_INSTR;
            if_pc_q     <= 32'h0;
            flush_q     <= 1'b0;
            trap_q      <= 1'b0;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            flush_q     <= flush_d;
            trap_q      <= trap_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_req      = (state_q == ST_FETCH);
    assign imem_addr     = pc_q;
    assign if_valid      = if_valid_q;
    assign if_instr      = if_instr_q;
    assign if_pc         = if_pc_q;
    assign flush         = flush_q;
    assign misalign_trap = trap_q;

endmodule
